// File: rtl/carry_save_resolver.sv
// Sequential carry-propagate adder: resolves a redundant (carry, sum) pair into one
// binary value, CHUNK_LEN bits per cycle, least-significant chunk first.
module carry_save_resolver #(
    parameter int BIT_LEN   = 1024,
    parameter int CHUNK_LEN = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] in_carry,
    input  logic [BIT_LEN-1:0] in_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN-1:0] out_result,
    output logic               out_carry
);

    localparam int NUM_CHUNKS = (BIT_LEN + CHUNK_LEN - 1) / CHUNK_LEN;
    localparam int PAD_W      = NUM_CHUNKS * CHUNK_LEN;
    localparam int LAST_W     = BIT_LEN - (NUM_CHUNKS - 1) * CHUNK_LEN;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               carry_reg;
    logic [PAD_W-1:0]   a_op;
    logic [PAD_W-1:0]   b_op;
    logic [PAD_W-1:0]   acc;
    logic [PAD_W-1:0]   acc_nxt;
    logic [CHUNK_LEN:0] csum;
    logic               accept;
    logic               last;

    function automatic logic [CHUNK_LEN:0] chunk_add(
        input logic [CHUNK_LEN-1:0] a,
        input logic [CHUNK_LEN-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{CHUNK_LEN{1'b0}}, cin};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (idx == LAST_IDX);

    // Operands shift down one chunk per cycle, so the active chunk is always at bit 0.
    assign csum    = chunk_add(a_op[CHUNK_LEN-1:0], b_op[CHUNK_LEN-1:0], carry_reg);
    assign acc_nxt = (acc >> CHUNK_LEN) | (PAD_W'(csum[CHUNK_LEN-1:0]) << (PAD_W - CHUNK_LEN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADD;
            ADD:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            carry_reg  <= 1'b0;
            a_op       <= '0;
            b_op       <= '0;
            acc        <= '0;
            out_result <= '0;
            out_carry  <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_op      <= PAD_W'(in_carry);
            b_op      <= PAD_W'(in_sum);
        end else if (state == ADD) begin
            idx       <= idx + 1'b1;
            carry_reg <= csum[CHUNK_LEN];
            a_op      <= a_op >> CHUNK_LEN;
            b_op      <= b_op >> CHUNK_LEN;
            acc       <= acc_nxt;
            // Padding above BIT_LEN is zero, so bit LAST_W of the last chunk sum is the true carry out.
            if (last) begin
                out_result <= acc_nxt[BIT_LEN-1:0];
                out_carry  <= csum[LAST_W];
            end
        end
    end

endmodule

// File: tb/tb_carry_save_resolver.sv
// Bench for carry_save_resolver: four instances (16/4, 18/4, 1024/64, 381/32) share
// clock, reset and stimulus; directed cases plus randomized traffic vs. an integer model.
module tb_carry_save_resolver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 in_valid;
    logic                 out_ready;
    logic [1:0]           sel;
    logic [1023:0]        drv_c;
    logic [1023:0]        drv_s;
    logic [3:0]           ir;
    logic [3:0]           ov;
    logic [3:0]           oc;
    logic [3:0][1023:0]   res;

    int n_assert = 0;
    int n_fail   = 0;
    int bl_of[4] = '{16, 18, 1024, 381};
    int nc_of[4] = '{4, 5, 16, 12};

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int BL = (g == 0) ? 16 : (g == 1) ? 18 : (g == 2) ? 1024 : 381;
        localparam int CL = (g == 0) ? 4 : (g == 1) ? 4 : (g == 2) ? 64 : 32;
        logic [BL-1:0] r;
        carry_save_resolver #(.BIT_LEN(BL), .CHUNK_LEN(CL)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid && (sel == 2'(g))),
            .in_ready  (ir[g]),
            .in_carry  (drv_c[BL-1:0]),
            .in_sum    (drv_s[BL-1:0]),
            .out_valid (ov[g]),
            .out_ready (out_ready && (sel == 2'(g))),
            .out_result(r),
            .out_carry (oc[g])
        );
        assign res[g] = 1024'(r);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int d;
        int w;
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            d = 0;
            for (int i = 1023; i >= 0; i--) if (obs[i] !== exp[i]) d = i;
            w = (d / 128) * 128;
            $error("FAIL %s: observed %h required %h (window from bit %0d)",
                   tag, 128'(obs >> w), 128'(exp >> w), w);
        end
    endtask

    function automatic logic [1023:0] rand1024();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: plain wide integer addition of the masked rows.
    function automatic void ref_add(input int bl, input logic [1023:0] c, input logic [1023:0] s,
                                    output logic [1023:0] r, output logic co);
        logic [1024:0] m;
        logic [1024:0] sum;
        m   = (1025'(1) << bl) - 1025'(1);
        sum = ({1'b0, c} & m) + ({1'b0, s} & m);
        r   = 1024'(sum & m);
        co  = sum[bl];
    endfunction

    task automatic start_op(input int g, input logic [1023:0] c, input logic [1023:0] s,
                            input string tag);
        int t;
        t   = 0;
        sel = 2'(g);
        while (!ir[g] && t < 100) begin
            tick();
            t++;
        end
        chk({tag, "_ready_before_accept"}, 1024'(ir[g]), 1024'(1));
        drv_c    = c;
        drv_s    = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drv_c    = rand1024();
        drv_s    = rand1024();
    endtask

    task automatic run_op(input int g, input logic [1023:0] c, input logic [1023:0] s,
                          input logic [1023:0] exp_r, input logic exp_c, input string tag,
                          input int gap_in, input int gap_out, input bit stab);
        logic [1023:0] hold;
        int lat;
        sel = 2'(g);
        repeat (gap_in) tick();
        hold = res[g];
        start_op(g, c, s, tag);
        lat = 0;
        while (!ov[g] && lat < 200) begin
            if (stab) chk({tag, "_held_during_add"}, res[g], hold);
            in_valid = 1'($urandom_range(0, 1));
            drv_c    = rand1024();
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 1024'(lat), 1024'(nc_of[g]));
        repeat (gap_out) tick();
        chk({tag, "_result"}, res[g], exp_r);
        chk({tag, "_carry"}, 1024'(oc[g]), 1024'(exp_c));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drops"}, 1024'(ov[g]), 1024'(0));
        chk({tag, "_ready_after"}, 1024'(ir[g]), 1024'(1));
    endtask

    initial begin
        logic [1023:0] c;
        logic [1023:0] s;
        logic [1023:0] er;
        logic [1023:0] hold;
        logic          ec;
        logic          hc;
        int            mode;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 2'd0;
        drv_c     = '0;
        drv_s     = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        for (int g = 0; g < 4; g++) begin
            chk("reset_in_ready", 1024'(ir[g]), 1024'(1));
            chk("reset_out_valid", 1024'(ov[g]), 1024'(0));
            chk("reset_out_result", res[g], 1024'(0));
            chk("reset_out_carry", 1024'(oc[g]), 1024'(0));
        end

        // 16/4 directed
        run_op(0, 1024'h00FF, 1024'h0001, 1024'h0100, 1'b0, "b16_ff_plus_1", 0, 0, 1'b1);
        run_op(0, 1024'hFFFF, 1024'h0001, 1024'h0000, 1'b1, "b16_full_prop", 1, 0, 1'b1);

        // 18/4 partial last chunk
        run_op(1, 1024'h3FFFF, 1024'h00001, 1024'h00000, 1'b1, "b18_full_prop", 0, 0, 1'b1);
        run_op(1, 1024'h20000, 1024'h00000, 1024'h20000, 1'b0, "b18_top_bit", 0, 1, 1'b1);

        // Backpressure in DONE with in_valid toggling and inputs changing
        start_op(0, 1024'h00FF, 1024'h0001, "bp");
        repeat (4) tick();
        chk("bp_valid_rise", 1024'(ov[0]), 1024'(1));
        hold = res[0];
        hc   = oc[0];
        chk("bp_result", hold, 1024'h0100);
        for (int k = 0; k < 10; k++) begin
            in_valid = ~in_valid;
            drv_c    = rand1024();
            drv_s    = rand1024();
            tick();
            chk("bp_valid_held", 1024'(ov[0]), 1024'(1));
            chk("bp_in_ready_low", 1024'(ir[0]), 1024'(0));
            chk("bp_result_stable", res[0], hold);
            chk("bp_carry_stable", 1024'(oc[0]), 1024'(hc));
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_handshake_valid", 1024'(ov[0]), 1024'(0));
        chk("bp_handshake_ready", 1024'(ir[0]), 1024'(1));
        tick();
        chk("bp_no_accept_on_handshake", 1024'(ir[0]), 1024'(1));

        // Reset in the middle of ADD
        run_op(0, 1024'hFFFF, 1024'h0002, 1024'h0001, 1'b1, "pre_reset", 0, 0, 1'b0);
        start_op(0, 1024'hFFFF, 1024'h0001, "mid_add");
        repeat (2) tick();
        chk("mid_add_busy", 1024'(ir[0]), 1024'(0));
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", 1024'(ov[0]), 1024'(0));
        chk("async_reset_result", res[0], 1024'(0));
        chk("async_reset_carry", 1024'(oc[0]), 1024'(0));
        tick();
        #2;
        reset_n = 1'b1;
        #1;
        chk("post_reset_ready", 1024'(ir[0]), 1024'(1));
        run_op(0, 1024'h1234, 1024'h4321, 1024'h5555, 1'b0, "post_reset_op", 0, 0, 1'b1);

        // Randomized traffic on the wide configurations
        for (int g = 2; g < 4; g++) begin
            for (int k = 0; k < 1500; k++) begin
                c    = rand1024();
                mode = int'($urandom_range(0, 3));
                case (mode)
                    0:       s = rand1024();
                    1:       s = ~c;
                    2:       s = ~c + 1024'(1);
                    default: begin
                        c = '1;
                        s = 1024'($urandom_range(0, 3));
                    end
                endcase
                ref_add(bl_of[g], c, s, er, ec);
                run_op(g, c, s, er, ec, (g == 2) ? "rand_1024" : "rand_381",
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
